// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode/func constants, ALU encodings, FSM states and the
// decoded-bundle record passed from the combinational decoder to the stage.
package decode_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;

  // The bundle carries a wide ALU field; the top narrows it to ALUOP_W.
  localparam int ALUOP_MAX_W = 8;
  localparam logic [ALUOP_MAX_W-1:0] ALU_ADD = 8'd0;
  localparam logic [ALUOP_MAX_W-1:0] ALU_SUB = 8'd1;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]             rs;
    logic [4:0]             rt;
    logic [4:0]             dst;
    logic                   regWr;
    logic                   memRd;
    logic                   memWr;
    logic                   aluSrc;
    logic                   branch;
    logic                   jump;
    logic                   jr;
    logic                   link;
    logic                   illegal;
    logic [ALUOP_MAX_W-1:0] aluOp;
    logic [31:0]            imm32;
    logic [25:0]            imm26;
  } decoded_t;

  // Widen the 16-bit immediate either by sign or by zero extension.
  function automatic logic [31:0] extendImm(input logic [15:0] imm, input logic signExt);
    extendImm = signExt ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational opcode/func table producing a decoded_t.
// Anything not in the table decodes as illegal with every control bit clear.
module decode_comb
  import decode_pkg::*;
#(
  parameter int SIGN_EXT = 1
) (
  input  logic [31:0] instr_i,
  output decoded_t    dec_o
);

  logic [5:0] opcode;
  logic [5:0] func;
  logic       unusedShamt;

  assign opcode      = instr_i[31:26];
  assign func        = instr_i[5:0];
  assign unusedShamt = ^instr_i[10:6];

  // Table lookup: register fields and immediates always pass through, control
  // bits and destination are only set by recognised encodings.
  always_comb begin
    dec_o       = '0;
    dec_o.rs    = instr_i[25:21];
    dec_o.rt    = instr_i[20:16];
    dec_o.imm26 = instr_i[25:0];
    dec_o.imm32 = extendImm(instr_i[15:0], SIGN_EXT != 0);
    dec_o.aluOp = ALU_ADD;
    dec_o.dst   = REG_ZERO;
    case (opcode)
      OP_SPECIAL: begin
        case (func)
          FN_ADD, FN_ADDU: begin
            dec_o.regWr = 1'b1;
            dec_o.dst   = instr_i[15:11];
          end
          FN_JR: begin
            dec_o.jr = 1'b1;
          end
          default: begin
            dec_o.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec_o.aluSrc = 1'b1;
        dec_o.regWr  = 1'b1;
        dec_o.dst    = instr_i[20:16];
      end
      OP_LW: begin
        dec_o.aluSrc = 1'b1;
        dec_o.memRd  = 1'b1;
        dec_o.regWr  = 1'b1;
        dec_o.dst    = instr_i[20:16];
      end
      OP_SW: begin
        dec_o.aluSrc = 1'b1;
        dec_o.memWr  = 1'b1;
      end
      OP_BEQ: begin
        dec_o.branch = 1'b1;
        dec_o.aluOp  = ALU_SUB;
      end
      OP_J: begin
        dec_o.jump = 1'b1;
      end
      OP_JAL: begin
        dec_o.jump  = 1'b1;
        dec_o.link  = 1'b1;
        dec_o.regWr = 1'b1;
        dec_o.dst   = REG_RA;
      end
      default: begin
        dec_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-entry registered decode stage with valid/ready handshake.
// Build option DECODE_HAZARD_DETECT_EN enables load-use hazard detection: a
// one-cycle BUBBLE is inserted and counted in a saturating stall counter.
// Without it, hazard is constant 0 and stall_count is tied to 0.
module decode_stage
  import decode_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int STALL_CNT_W = 16,
  parameter int SIGN_EXT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instruction,
  input  logic [31:0]            pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            pc_out,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             dst,
  output logic                   reg_wr,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic                   alu_src,
  output logic                   branch,
  output logic                   jump,
  output logic                   jr,
  output logic                   link,
  output logic                   illegal,
  output logic [ALUOP_W-1:0]     alu_op,
  output logic [31:0]            imm32,
  output logic [25:0]            imm26,
  output logic [STALL_CNT_W-1:0] stall_count
);

  state_t   state_q;
  state_t   state_d;
  decoded_t bundle_q;
  decoded_t decoded;
  logic [31:0] pc_q;
  logic        hazard;
  logic        accept;

  decode_comb #(
    .SIGN_EXT(SIGN_EXT)
  ) u_decode_comb (
    .instr_i(instruction),
    .dec_o  (decoded)
  );

  assign out_valid = (state_q == FULL);
  assign in_ready  = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

`ifdef DECODE_HAZARD_DETECT_EN
  logic                   enterBubble;
  logic [STALL_CNT_W-1:0] stallCount_q;

  // Load-use: the held load is leaving now and the new instruction reads its result.
  assign hazard = in_valid && out_valid && out_ready && bundle_q.memRd &&
                  (bundle_q.dst != REG_ZERO) &&
                  ((bundle_q.dst == instruction[25:21]) || (bundle_q.dst == instruction[20:16]));

  assign enterBubble = (state_q == FULL) && hazard && !flush;

  // Saturating count of inserted bubbles; flush never counts since it cancels the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount_q <= '0;
    end else if (enterBubble && (stallCount_q != '1)) begin
      stallCount_q <= stallCount_q + STALL_CNT_W'(1);
    end
  end

  assign stall_count = stallCount_q;
`else
  assign hazard      = 1'b0;
  assign stall_count = '0;
`endif

  // Next-state logic for the output register; flush takes priority over everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (hazard) begin
          state_d = BUBBLE;
        end else if (out_ready) begin
          state_d = accept ? FULL : EMPTY;
        end
      end
      BUBBLE: begin
        state_d = accept ? FULL : EMPTY;
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) state_d = EMPTY;
  end

  // State and payload registers; payload only changes on accept so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      bundle_q <= '0;
      pc_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bundle_q <= decoded;
        pc_q     <= pc;
      end
    end
  end

  assign pc_out  = pc_q;
  assign rs      = bundle_q.rs;
  assign rt      = bundle_q.rt;
  assign dst     = bundle_q.dst;
  assign reg_wr  = bundle_q.regWr;
  assign mem_rd  = bundle_q.memRd;
  assign mem_wr  = bundle_q.memWr;
  assign alu_src = bundle_q.aluSrc;
  assign branch  = bundle_q.branch;
  assign jump    = bundle_q.jump;
  assign jr      = bundle_q.jr;
  assign link    = bundle_q.link;
  assign illegal = bundle_q.illegal;
  assign alu_op  = ALUOP_W'(bundle_q.aluOp);
  assign imm32   = bundle_q.imm32;
  assign imm26   = bundle_q.imm26;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode checks plus directed handshake sequences
// (load-use bubble, backpressure, flush, reset mid-stall, counter saturation).
module tb_decode_stage;

  // Narrow counter so saturation is reachable in a short run.
  localparam int CNT_W = 8;

  localparam logic [8:0] C_REGWR  = 9'h100;
  localparam logic [8:0] C_MEMRD  = 9'h080;
  localparam logic [8:0] C_MEMWR  = 9'h040;
  localparam logic [8:0] C_ALUSRC = 9'h020;
  localparam logic [8:0] C_BRANCH = 9'h010;
  localparam logic [8:0] C_JUMP   = 9'h008;
  localparam logic [8:0] C_JR     = 9'h004;
  localparam logic [8:0] C_LINK   = 9'h002;
  localparam logic [8:0] C_ILL    = 9'h001;

  localparam logic [31:0] I_ADD17 = 32'h03E08820;
  localparam logic [31:0] I_LW    = 32'h8D280004;
  localparam logic [31:0] I_ADD10 = 32'h01085020;
  localparam logic [31:0] I_ADDI  = 32'h2043FFFF;
  localparam logic [31:0] I_J     = 32'h08000100;
  localparam logic [31:0] I_ADDU  = 32'h00851021;
  localparam logic [31:0] I_SW    = 32'hACC70008;

  typedef struct {
    logic [31:0] instr;
    logic [8:0]  ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [2:0]  aluOp;
    logic [31:0] imm32;
    logic [25:0] imm26;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] instruction, pc;
  logic in_ready, out_valid;
  logic [31:0] pc_out, imm32;
  logic [4:0] rs, rt, dst;
  logic reg_wr, mem_rd, mem_wr, alu_src, branch, jump, jr, link, illegal;
  logic [2:0] alu_op;
  logic [25:0] imm26;
  logic [CNT_W-1:0] stall_count;
  logic [8:0] ctrlAct;

  int errors = 0;
  int checks = 0;
  int expCount = 0;
  vec_t vecs[13];

  always #5 clk = ~clk;

  assign ctrlAct = {reg_wr, mem_rd, mem_wr, alu_src, branch, jump, jr, link, illegal};

  decode_stage #(
    .ALUOP_W    (3),
    .STALL_CNT_W(CNT_W),
    .SIGN_EXT   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instruction(instruction),
    .pc         (pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pc_out     (pc_out),
    .rs         (rs),
    .rt         (rt),
    .dst        (dst),
    .reg_wr     (reg_wr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .alu_src    (alu_src),
    .branch     (branch),
    .jump       (jump),
    .jr         (jr),
    .link       (link),
    .illegal    (illegal),
    .alu_op     (alu_op),
    .imm32      (imm32),
    .imm26      (imm26),
    .stall_count(stall_count)
  );

  function automatic vec_t mkVec(input logic [31:0] ins, input logic [8:0] c,
                                 input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                 input logic [2:0] a, input logic [31:0] i32, input logic [25:0] i26);
    vec_t v;
    v.instr = ins; v.ctrl = c; v.rs = s; v.rt = t; v.dst = d;
    v.aluOp = a; v.imm32 = i32; v.imm26 = i26;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs just after an edge, then let combinational in_ready settle.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                               input logic ordy, input logic fl);
    in_valid = v; instruction = ins; pc = p; out_ready = ordy; flush = fl;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = mkVec(I_ADD17,      C_REGWR,            5'd31, 5'd0, 5'd17, 3'd0, 32'hFFFF8820, 26'h3E08820);
    vecs[1]  = mkVec(I_ADDU,       C_REGWR,            5'd4,  5'd5, 5'd2,  3'd0, 32'h00001021, 26'h0851021);
    vecs[2]  = mkVec(32'h03E00008, C_JR,               5'd31, 5'd0, 5'd0,  3'd0, 32'h00000008, 26'h3E00008);
    vecs[3]  = mkVec(I_ADDI,       C_ALUSRC | C_REGWR, 5'd2,  5'd3, 5'd3,  3'd0, 32'hFFFFFFFF, 26'h043FFFF);
    vecs[4]  = mkVec(32'h24A57FFF, C_ALUSRC | C_REGWR, 5'd5,  5'd5, 5'd5,  3'd0, 32'h00007FFF, 26'h0A57FFF);
    vecs[5]  = mkVec(I_LW,         C_ALUSRC | C_MEMRD | C_REGWR, 5'd9, 5'd8, 5'd8, 3'd0, 32'h00000004, 26'h1280004);
    vecs[6]  = mkVec(I_SW,         C_ALUSRC | C_MEMWR, 5'd6,  5'd7, 5'd0,  3'd0, 32'h00000008, 26'h0C70008);
    vecs[7]  = mkVec(32'h1022FFFC, C_BRANCH,           5'd1,  5'd2, 5'd0,  3'd1, 32'hFFFFFFFC, 26'h022FFFC);
    vecs[8]  = mkVec(I_J,          C_JUMP,             5'd0,  5'd0, 5'd0,  3'd0, 32'h00000100, 26'h0000100);
    vecs[9]  = mkVec(32'h0C000010, C_JUMP | C_LINK | C_REGWR, 5'd0, 5'd0, 5'd31, 3'd0, 32'h00000010, 26'h0000010);
    vecs[10] = mkVec(32'hFC221234, C_ILL,              5'd1,  5'd2, 5'd0,  3'd0, 32'h00001234, 26'h0221234);
    vecs[11] = mkVec(32'h00000000, C_ILL,              5'd0,  5'd0, 5'd0,  3'd0, 32'h00000000, 26'h0000000);
    vecs[12] = mkVec(32'h00430822, C_ILL,              5'd2,  5'd3, 5'd0,  3'd0, 32'h00000822, 26'h0430822);

    // Reset with a valid instruction offered: nothing accepted, everything zero.
    rst = 1'b1;
    applyStimulus(1'b1, I_ADD17, 32'h100, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("rst in_ready", in_ready, 0);
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst stall_count", stall_count, 0);
    checkOutput("rst pc_out", pc_out, 0);
    checkOutput("rst ctrl", ctrlAct, 0);
    checkOutput("rst dst", dst, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("post-rst out_valid", out_valid, 0);

    // Single add: one-cycle latency.
    applyStimulus(1'b1, I_ADD17, 32'h200, 1'b1, 1'b0);
    checkOutput("add in_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("add out_valid", out_valid, 1);
    checkOutput("add rs", rs, 31);
    checkOutput("add rt", rt, 0);
    checkOutput("add dst", dst, 17);
    checkOutput("add ctrl", ctrlAct, C_REGWR);
    checkOutput("add pc_out", pc_out, 32'h200);
    tick();
    checkOutput("add drained", out_valid, 0);

    // Load-use pair.
    applyStimulus(1'b1, I_LW, 32'h300, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, I_ADD10, 32'h304, 1'b1, 1'b0);
`ifdef DECODE_HAZARD_DETECT_EN
    checkOutput("lu in_ready hazard", in_ready, 0);
    tick();
    checkOutput("lu bubble out_valid", out_valid, 0);
    checkOutput("lu stall_count", stall_count, 1);
    checkOutput("lu in_ready bubble", in_ready, 1);
    tick();
    expCount = 1;
`else
    checkOutput("lu in_ready", in_ready, 1);
    tick();
    expCount = 0;
`endif
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("lu add out_valid", out_valid, 1);
    checkOutput("lu add dst", dst, 10);
    checkOutput("lu add pc_out", pc_out, 32'h304);
    checkOutput("lu count after", stall_count, expCount);
    tick();

    // Backpressure for three cycles, then release with no gap.
    applyStimulus(1'b1, I_ADDI, 32'h400, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, I_J, 32'h404, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp in_ready", in_ready, 0);
      tick();
      checkOutput("bp out_valid", out_valid, 1);
      checkOutput("bp pc_out", pc_out, 32'h400);
      checkOutput("bp dst", dst, 3);
      checkOutput("bp imm32", imm32, 32'hFFFFFFFF);
    end
    applyStimulus(1'b1, I_J, 32'h404, 1'b1, 1'b0);
    checkOutput("bp release in_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp next out_valid", out_valid, 1);
    checkOutput("bp next pc_out", pc_out, 32'h404);
    checkOutput("bp next ctrl", ctrlAct, C_JUMP);
    tick();

    // Flush while FULL with a valid instruction offered.
    applyStimulus(1'b1, I_ADDU, 32'h500, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, I_SW, 32'h504, 1'b1, 1'b1);
    checkOutput("flush in_ready", in_ready, 0);
    tick();
    checkOutput("flush out_valid", out_valid, 0);
    checkOutput("flush stall_count", stall_count, expCount);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("flush still empty", out_valid, 0);
    checkOutput("flush pc not taken", pc_out, 32'h500);

    // Decode table, back-to-back.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(i) * 4, 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d in_ready", i), in_ready, 1);
      tick();
      checkOutput($sformatf("vec%0d out_valid", i), out_valid, 1);
      checkOutput($sformatf("vec%0d ctrl", i), ctrlAct, vecs[i].ctrl);
      checkOutput($sformatf("vec%0d regs", i), {rs, rt, dst}, {vecs[i].rs, vecs[i].rt, vecs[i].dst});
      checkOutput($sformatf("vec%0d alu_op", i), alu_op, vecs[i].aluOp);
      checkOutput($sformatf("vec%0d imm32", i), imm32, vecs[i].imm32);
      checkOutput($sformatf("vec%0d imm26", i), imm26, vecs[i].imm26);
      checkOutput($sformatf("vec%0d pc_out", i), pc_out, 32'h1000 + 32'(i) * 4);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("table drained", out_valid, 0);
    checkOutput("table stall_count", stall_count, expCount);

`ifdef DECODE_HAZARD_DETECT_EN
    // Reset while in BUBBLE discards both the bubble and the waiting add.
    applyStimulus(1'b1, I_LW, 32'h600, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, I_ADD10, 32'h604, 1'b1, 1'b0);
    tick();
    checkOutput("rstmid bubble", out_valid, 0);
    checkOutput("rstmid count", stall_count, expCount + 1);
    rst = 1'b1;
    applyStimulus(1'b1, I_ADD10, 32'h604, 1'b1, 1'b0);
    checkOutput("rstmid in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("rstmid out_valid", out_valid, 0);
    checkOutput("rstmid count cleared", stall_count, 0);
    tick();
    checkOutput("rstmid add dropped", out_valid, 0);

    // Drive the counter to all-ones, then one hazard past it.
    applyStimulus(1'b1, I_LW, 32'h700, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < (1 << CNT_W) - 1; k++) begin
      applyStimulus(1'b1, I_ADD10, 32'h704, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, I_LW, 32'h700, 1'b1, 1'b0);
      tick();
    end
    checkOutput("sat reach max", stall_count, {CNT_W{1'b1}});
    applyStimulus(1'b1, I_ADD10, 32'h704, 1'b1, 1'b0);
    tick();
    checkOutput("sat extra bubble", out_valid, 0);
    checkOutput("sat hold max", stall_count, {CNT_W{1'b1}});
`else
    // Repeated load-use pairs never bubble and never count.
    applyStimulus(1'b1, I_LW, 32'h700, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, I_ADD10, 32'h704, 1'b1, 1'b0);
      tick();
      checkOutput("nohaz add valid", out_valid, 1);
      checkOutput("nohaz add pc", pc_out, 32'h704);
      applyStimulus(1'b1, I_LW, 32'h700, 1'b1, 1'b0);
      tick();
      checkOutput("nohaz lw valid", out_valid, 1);
    end
    checkOutput("nohaz count", stall_count, 0);
`endif

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ALUOP_W, default 3: width of alu_op.
REQ-002 Parameter STALL_CNT_W, default 16: width of stall_count.
REQ-003 Parameter SIGN_EXT, default 1: 1 sign-extends imm16 to imm32, 0 zero-extends.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-005 Ports, as name / direction / width / meaning:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard held instruction.
- in_valid  in  1  instruction/pc valid.
- in_ready  out  1  stage accepts input.
- instruction  in  32  fetched word.
- pc  in  32  fetch address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- pc_out  out  32  registered pc.
- rs, rt  out  5 each  source register fields.
- dst  out  5  resolved destination register.
- reg_wr, mem_rd, mem_wr, alu_src, branch, jump, jr, link, illegal  out  1 each  control bits.
- alu_op  out  ALUOP_W  ALU operation.
- imm32  out  32  extended imm16.
- imm26  out  26  jump target field.
- stall_count  out  STALL_CNT_W  hazard bubbles inserted, saturating.

Function
REQ-006 Decoding SHALL follow this table:
- op 0x00 with func 0x20/0x21: reg_wr, dst=rd.
- op 0x00 with func 0x08: jr, reg_wr=0.
- op 0x08/0x09: alu_src, reg_wr, dst=rt.
- op 0x23: alu_src, mem_rd, reg_wr, dst=rt.
- op 0x2B: alu_src, mem_wr.
- op 0x04: branch, alu_op=1.
- op 0x02: jump.
- op 0x03: jump, link, reg_wr, dst=31.
- All other op/func values: every control bit 0 and illegal=1; the instruction is still passed downstream as valid.
REQ-007 For decodes with no destination, dst SHALL be 0. Unlisted control bits SHALL be 0, and alu_op SHALL be 0 unless the table sets it.
REQ-008 The stage SHALL have a one-entry output register. Latency is 1 cycle from accept (in_valid & in_ready) to out_valid.
REQ-009 in_ready SHALL equal !flush & !hazard & (!out_valid | out_ready).
REQ-010 hazard SHALL be the AND of all of:
- in_valid;
- out_valid & out_ready;
- mem_rd held;
- dst held != 0;
- dst held equals the incoming instruction's rs, or its rt.
REQ-011 The FSM SHALL have states EMPTY, FULL and BUBBLE:
- EMPTY: on accept go to FULL.
- FULL: if consumed with no accept, go to EMPTY; if consumed with accept, stay FULL; if hazard, go to BUBBLE.
- BUBBLE: out_valid=0 for exactly one cycle; on accept go to FULL, otherwise go to EMPTY.
REQ-012 out_valid SHALL be 1 only in FULL. Outputs SHALL hold stable while out_valid & !out_ready.
REQ-013 flush SHALL override all other events: next state EMPTY, no accept that cycle, and stall_count is not incremented.
REQ-014 stall_count SHALL increment on each entry to BUBBLE and saturate at all-ones.

Reset
REQ-015 While rst=1, the block SHALL apply:
- state EMPTY, out_valid=0, stall_count=0;
- all registered outputs 0.
REQ-016 in_ready SHALL be 0 during rst. Reset mid-stall SHALL discard the BUBBLE and the pending instruction.

Configuration
REQ-017 Macro DECODE_HAZARD_DETECT_EN controls hazard detection:
- Defined: REQ-010, REQ-011 BUBBLE handling and REQ-014 apply.
- Undefined: hazard is constant 0, BUBBLE is never entered, and stall_count is tied to 0.

Structure
REQ-018 Package decode_pkg SHALL hold:
- opcode and func localparams;
- alu_op encodings;
- the FSM state enum;
- a decoded-bundle struct typedef.
REQ-019 The opcode/func table SHALL live in the combinational sub-module decode_comb. decode_stage instantiates it and adds the registers, FSM and counter.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- add 0x03E08820 accepted with out_ready=1 -> next cycle out_valid=1, rs=31, rt=0, dst=17, reg_wr=1.
- lw $8,4($9), then add $10,$8,$8 presented while the lw is consumed -> exactly one out_valid=0 cycle, then the add; stall_count=1.
- out_ready=0 for 3 cycles with FULL and in_valid=1 -> in_ready=0 and outputs stable; release -> the next instruction follows with no gap.
- flush asserted while FULL and in_valid=1 -> next cycle out_valid=0, that instruction is not accepted, and stall_count is unchanged.
- opcode 0x3F -> out_valid=1, illegal=1, all control bits 0; jal 0x0C000010 -> link=1, dst=31, imm26=0x10.
- stall_count at 0xFFFF plus one more hazard -> stays 0xFFFF; with the macro undefined, the same load-use pair -> no bubble and count 0.
